// File: rtl/cpu_run_controller.sv
// Run controller for the single-cycle RISC-V core: loads instruction memory over a
// command handshake, sequences the core's start input and reports why and when it stopped.
module cpu_run_controller #(
   parameter int unsigned IMEM_DEPTH = 256,
   parameter int unsigned ADDR_W     = 8,
   parameter int unsigned CNT_W      = 32,
   parameter int unsigned MAX_CYCLES = 0,
   parameter logic [31:0] HALT_INST  = 32'h00100073
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [1:0]        cmd_op,
   input  logic [31:0]       cmd_data,
   output logic              imem_we,
   output logic [ADDR_W-1:0] imem_waddr,
   output logic [31:0]       imem_wdata,
   output logic              cpu_start,
   input  logic [31:0]       cpu_pc,
   input  logic [31:0]       cpu_inst,
   output logic              busy,
   output logic              halted,
   output logic [1:0]        halt_cause,
   output logic [CNT_W-1:0]  cycle_count,
   output logic              cmd_err
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_ARM  = 2'b01,
      ST_RUN  = 2'b10,
      ST_HALT = 2'b11
   } state_e;

   localparam logic [1:0] OP_LOAD  = 2'b00;
   localparam logic [1:0] OP_RUN   = 2'b01;
   localparam logic [1:0] OP_CLEAR = 2'b10;
   localparam logic [1:0] OP_ABORT = 2'b11;

   localparam logic [1:0] CAUSE_ABORT = 2'b00;
   localparam logic [1:0] CAUSE_HALT  = 2'b01;
   localparam logic [1:0] CAUSE_LOOP  = 2'b10;
   localparam logic [1:0] CAUSE_LIMIT = 2'b11;

   // One extra pointer bit so a completely full memory is distinguishable from empty.
   localparam int unsigned       PTR_W    = ADDR_W + 1;
   localparam logic [PTR_W-1:0]  DEPTH_P  = PTR_W'(IMEM_DEPTH);
   localparam logic [CNT_W:0]    MAX_P    = (CNT_W + 1)'(MAX_CYCLES);
   localparam logic              LIMIT_EN = (MAX_CYCLES != 0);

   state_e              state_q, state_d;
   logic [PTR_W-1:0]    ptr_q, ptr_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [1:0]          cause_q, cause_d;
   logic                err_q, err_d;
   logic [31:0]         prev_pc_q, prev_pc_d;
   logic                prev_valid_q, prev_valid_d;
   logic                we_q, we_d;
   logic [ADDR_W-1:0]   waddr_q, waddr_d;
   logic [31:0]         wdata_q, wdata_d;
   logic                start_q, start_d;
   logic                busy_q, busy_d;
   logic                halted_q, halted_d;
   logic                ready_q, ready_d;

   logic                accept_s;
   logic [CNT_W:0]      cnt_plus1_s;
   logic [CNT_W-1:0]    cnt_sat_s;

   assign accept_s    = cmd_valid & ready_q;
   assign cnt_plus1_s = {1'b0, cnt_q} + (CNT_W + 1)'(1);
   assign cnt_sat_s   = cnt_plus1_s[CNT_W] ? cnt_q : cnt_plus1_s[CNT_W-1:0];

   // Status outputs are registered from the next state so they line up with it.
   assign start_d  = (state_d == ST_RUN);
   assign busy_d   = (state_d == ST_ARM) | (state_d == ST_RUN);
   assign halted_d = (state_d == ST_HALT);
   assign ready_d  = (state_d != ST_ARM);

   // Next-state, command decode and run-monitor logic.
   always_comb begin
      state_d      = state_q;
      ptr_d        = ptr_q;
      cnt_d        = cnt_q;
      cause_d      = cause_q;
      err_d        = err_q;
      prev_pc_d    = prev_pc_q;
      prev_valid_d = prev_valid_q;
      we_d         = 1'b0;
      waddr_d      = waddr_q;
      wdata_d      = wdata_q;

      case (state_q)
         ST_IDLE, ST_HALT: begin
            if (accept_s) begin
               case (cmd_op)
                  OP_LOAD: begin
                     if (ptr_q == DEPTH_P) begin
                        err_d = 1'b1;
                     end else begin
                        we_d    = 1'b1;
                        waddr_d = ptr_q[ADDR_W-1:0];
                        wdata_d = cmd_data;
                        ptr_d   = ptr_q + PTR_W'(1);
                     end
                  end
                  OP_RUN: begin
                     state_d      = ST_ARM;
                     ptr_d        = '0;
                     cnt_d        = '0;
                     cause_d      = CAUSE_ABORT;
                     prev_valid_d = 1'b0;
                  end
                  OP_CLEAR: begin
                     state_d = ST_IDLE;
                     ptr_d   = '0;
                     cnt_d   = '0;
                     cause_d = CAUSE_ABORT;
                     err_d   = 1'b0;
                  end
                  OP_ABORT: begin
                     state_d = state_q;
                  end
                  default: begin
                     state_d = state_q;
                  end
               endcase
            end else begin
               state_d = state_q;
            end
         end

         // The core is held in reset for this whole cycle before it is released.
         ST_ARM: begin
            state_d = ST_RUN;
         end

         ST_RUN: begin
            cnt_d        = cnt_sat_s;
            prev_pc_d    = cpu_pc;
            prev_valid_d = 1'b1;
            if (accept_s && (cmd_op == OP_ABORT)) begin
               state_d = ST_HALT;
               cause_d = CAUSE_ABORT;
            end else if (cpu_inst == HALT_INST) begin
               state_d = ST_HALT;
               cause_d = CAUSE_HALT;
            end else if (prev_valid_q && (cpu_pc == prev_pc_q)) begin
               state_d = ST_HALT;
               cause_d = CAUSE_LOOP;
            end else if (LIMIT_EN && (cnt_plus1_s == MAX_P)) begin
               state_d = ST_HALT;
               cause_d = CAUSE_LIMIT;
            end else begin
               state_d = ST_RUN;
            end
            // Anything but ABORT is swallowed while the core runs and flagged.
            if (accept_s && (cmd_op != OP_ABORT)) begin
               err_d = 1'b1;
            end else begin
               err_d = err_q;
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and output registers; reset also drops cpu_start and imem_we at once.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= ST_IDLE;
         ptr_q        <= '0;
         cnt_q        <= '0;
         cause_q      <= 2'b00;
         err_q        <= 1'b0;
         prev_pc_q    <= 32'h0000_0000;
         prev_valid_q <= 1'b0;
         we_q         <= 1'b0;
         waddr_q      <= '0;
         wdata_q      <= 32'h0000_0000;
         start_q      <= 1'b0;
         busy_q       <= 1'b0;
         halted_q     <= 1'b0;
         ready_q      <= 1'b1;
      end else begin
         state_q      <= state_d;
         ptr_q        <= ptr_d;
         cnt_q        <= cnt_d;
         cause_q      <= cause_d;
         err_q        <= err_d;
         prev_pc_q    <= prev_pc_d;
         prev_valid_q <= prev_valid_d;
         we_q         <= we_d;
         waddr_q      <= waddr_d;
         wdata_q      <= wdata_d;
         start_q      <= start_d;
         busy_q       <= busy_d;
         halted_q     <= halted_d;
         ready_q      <= ready_d;
      end
   end

   assign cmd_ready   = ready_q;
   assign imem_we     = we_q;
   assign imem_waddr  = waddr_q;
   assign imem_wdata  = wdata_q;
   assign cpu_start   = start_q;
   assign busy        = busy_q;
   assign halted      = halted_q;
   assign halt_cause  = cause_q;
   assign cycle_count = cnt_q;
   assign cmd_err     = err_q;

endmodule

// File: tb/tb_cpu_run_controller.sv
// Directed bench for cpu_run_controller with a tiny fetch-only CPU model driving the PC taps.
module tb_cpu_run_controller;

   localparam int unsigned ADDR_W = 2;
   localparam int unsigned CNT_W  = 32;
   localparam logic [31:0] HALT   = 32'h00100073;
   localparam logic [31:0] NOP    = 32'h00000013;
   localparam logic [31:0] SELF   = 32'h00000063;

   localparam logic [1:0] OP_LOAD  = 2'b00;
   localparam logic [1:0] OP_RUN   = 2'b01;
   localparam logic [1:0] OP_CLEAR = 2'b10;
   localparam logic [1:0] OP_ABORT = 2'b11;

   logic              clk = 1'b0;
   logic              rst;
   logic              cmd_valid;
   logic              cmd_ready;
   logic [1:0]        cmd_op;
   logic [31:0]       cmd_data;
   logic              imem_we;
   logic [ADDR_W-1:0] imem_waddr;
   logic [31:0]       imem_wdata;
   logic              cpu_start;
   logic [31:0]       cpu_pc;
   logic [31:0]       cpu_inst;
   logic              busy;
   logic              halted;
   logic [1:0]        halt_cause;
   logic [CNT_W-1:0]  cycle_count;
   logic              cmd_err;

   int n_chk  = 0;
   int n_pass = 0;

   cpu_run_controller #(
      .IMEM_DEPTH (4),
      .ADDR_W     (ADDR_W),
      .CNT_W      (CNT_W),
      .MAX_CYCLES (5),
      .HALT_INST  (HALT)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .cmd_valid   (cmd_valid),
      .cmd_ready   (cmd_ready),
      .cmd_op      (cmd_op),
      .cmd_data    (cmd_data),
      .imem_we     (imem_we),
      .imem_waddr  (imem_waddr),
      .imem_wdata  (imem_wdata),
      .cpu_start   (cpu_start),
      .cpu_pc      (cpu_pc),
      .cpu_inst    (cpu_inst),
      .busy        (busy),
      .halted      (halted),
      .halt_cause  (halt_cause),
      .cycle_count (cycle_count),
      .cmd_err     (cmd_err)
   );

   always #5 clk = ~clk;

   // CPU model: PC held at 0 while start is low, otherwise +4 except on the self-branch.
   logic [31:0] mem [0:3];
   logic [31:0] pc_q;

   always @(posedge clk) begin
      if (imem_we) mem[imem_waddr] <= imem_wdata;
      if (!cpu_start) pc_q <= 32'h0;
      else if (cpu_inst != SELF) pc_q <= pc_q + 32'd4;
   end

   assign cpu_pc   = pc_q;
   assign cpu_inst = (pc_q[31:4] == 28'h0) ? mem[pc_q[3:2]] : NOP;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
   endtask

   task automatic send(input logic [1:0] op, input logic [31:0] d);
      cmd_valid = 1'b1;
      cmd_op    = op;
      cmd_data  = d;
      @(negedge clk);
      cmd_valid = 1'b0;
   endtask

   task automatic wait_halt(output int starts);
      logic ok;
      ok     = 1'b0;
      starts = 0;
      for (int n = 0; n < 40; n++) begin
         if (halted) begin
            ok = 1'b1;
            break;
         end
         if (cpu_start) starts++;
         @(negedge clk);
      end
      check("halt_reached", 32'(ok), 32'd1);
   endtask

   logic [31:0] prog1 [3] = '{32'h00500093, 32'h00000013, 32'h00100073};
   int starts;

   initial begin
      rst = 1'b0; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_data = 32'h0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check("rst_ready",  32'(cmd_ready),  32'd1);
      check("rst_busy",   32'(busy),       32'd0);
      check("rst_halted", 32'(halted),     32'd0);
      check("rst_start",  32'(cpu_start),  32'd0);
      check("rst_we",     32'(imem_we),    32'd0);
      check("rst_cause",  32'(halt_cause), 32'd0);
      check("rst_count",  cycle_count,     32'd0);
      check("rst_err",    32'(cmd_err),    32'd0);

      // 1: three back-to-back loads write on three consecutive cycles
      cmd_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         cmd_op = OP_LOAD; cmd_data = prog1[i];
         @(negedge clk);
         check("t1_we",   32'(imem_we),    32'd1);
         check("t1_addr", 32'(imem_waddr), 32'(i));
         check("t1_data", imem_wdata,      prog1[i]);
      end
      cmd_valid = 1'b0;
      @(negedge clk);
      check("t1_we_off", 32'(imem_we), 32'd0);
      check("t1_err",    32'(cmd_err), 32'd0);

      // 2: run to the ebreak in the third word
      send(OP_RUN, 32'h0);
      check("t2_arm_busy",  32'(busy),      32'd1);
      check("t2_arm_start", 32'(cpu_start), 32'd0);
      check("t2_arm_ready", 32'(cmd_ready), 32'd0);
      wait_halt(starts);
      check("t2_starts", 32'(starts),     32'd3);
      check("t2_cause",  32'(halt_cause), 32'd1);
      check("t2_count",  cycle_count,     32'd3);
      check("t2_busy",   32'(busy),       32'd0);
      check("t2_start",  32'(cpu_start),  32'd0);

      // 3: self-branch at word 0 stops in the second run cycle
      send(OP_LOAD, SELF);
      check("t3_we",   32'(imem_we),    32'd1);
      check("t3_addr", 32'(imem_waddr), 32'd0);
      send(OP_RUN, 32'h0);
      wait_halt(starts);
      check("t3_starts", 32'(starts),     32'd2);
      check("t3_cause",  32'(halt_cause), 32'd2);
      check("t3_count",  cycle_count,     32'd2);

      // 4: straight-line nops stop at the 5-cycle limit
      for (int i = 0; i < 4; i++) send(OP_LOAD, NOP);
      send(OP_RUN, 32'h0);
      wait_halt(starts);
      check("t4_starts", 32'(starts),     32'd5);
      check("t4_cause",  32'(halt_cause), 32'd3);
      check("t4_count",  cycle_count,     32'd5);

      // 5a: abort in the same cycle as the ebreak fetch wins
      send(OP_LOAD, NOP);
      send(OP_LOAD, HALT);
      send(OP_RUN, 32'h0);
      @(negedge clk);
      @(negedge clk);
      check("t5_run_start", 32'(cpu_start), 32'd1);
      send(OP_ABORT, 32'h0);
      check("t5_halted", 32'(halted),     32'd1);
      check("t5_cause",  32'(halt_cause), 32'd0);
      check("t5_count",  cycle_count,     32'd2);
      check("t5_start",  32'(cpu_start),  32'd0);

      // 5b: load during run is rejected, then clear from halt
      send(OP_RUN, 32'h0);
      @(negedge clk);
      send(OP_LOAD, 32'hDEADBEEF);
      check("t5b_we",    32'(imem_we),   32'd0);
      check("t5b_err",   32'(cmd_err),   32'd1);
      check("t5b_start", 32'(cpu_start), 32'd1);
      @(negedge clk);
      check("t5b_halted", 32'(halted),     32'd1);
      check("t5b_cause",  32'(halt_cause), 32'd1);
      check("t5b_count",  cycle_count,     32'd2);
      send(OP_ABORT, 32'h0);
      check("t5b_abort_halted", 32'(halted),     32'd1);
      check("t5b_abort_cause",  32'(halt_cause), 32'd1);
      send(OP_CLEAR, 32'h0);
      check("t5c_err",    32'(cmd_err),    32'd0);
      check("t5c_halted", 32'(halted),     32'd0);
      check("t5c_busy",   32'(busy),       32'd0);
      check("t5c_count",  cycle_count,     32'd0);
      check("t5c_cause",  32'(halt_cause), 32'd0);
      check("t5c_ready",  32'(cmd_ready),  32'd1);

      // 6: fifth load into a 4-word memory is refused
      cmd_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         cmd_op = OP_LOAD; cmd_data = NOP;
         @(negedge clk);
         if (i < 4) begin
            check("t6_we",   32'(imem_we),    32'd1);
            check("t6_addr", 32'(imem_waddr), 32'(i));
            check("t6_err",  32'(cmd_err),    32'd0);
         end else begin
            check("t6_over_we",  32'(imem_we), 32'd0);
            check("t6_over_err", 32'(cmd_err), 32'd1);
         end
      end
      cmd_valid = 1'b0;

      // 6b: asynchronous reset in the middle of a run
      send(OP_RUN, 32'h0);
      @(negedge clk);
      @(negedge clk);
      check("t6_pre_count", cycle_count,    32'd1);
      check("t6_pre_start", 32'(cpu_start), 32'd1);
      #1 rst = 1'b0;
      #1;
      check("t6_rst_start", 32'(cpu_start), 32'd0);
      check("t6_rst_busy",  32'(busy),      32'd0);
      check("t6_rst_count", cycle_count,    32'd0);
      check("t6_rst_err",   32'(cmd_err),   32'd0);
      #1 rst = 1'b1;
      @(negedge clk);
      check("t6_post_ready", 32'(cmd_ready), 32'd1);
      send(OP_LOAD, NOP);
      check("t6_post_we",   32'(imem_we),    32'd1);
      check("t6_post_addr", 32'(imem_waddr), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
